mux_n_reg: RTL and testbench

//   Parametrised N-way, WIDTH-bit multiplexer with a registered output stage and valid/ready handshake.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/rr_pick.sv | 27 ++
 rtl/mux_n_reg.sv | 91 +++++++++
 tb/tb_mux_n_reg.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath constants for the 24-bit pipeline blocks.
package cpu_pkg;
  localparam int   WORD_W   = 24;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first asserted req scanning ptr, ptr+1, ... with wrap at N.
module rr_pick #(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  int k;

  // Scan highest offset first so the nearest requester to ptr is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    k   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (req[k]) begin
        any = 1'b1;
        idx = SEL_W'(k);
      end
    end
  end
endmodule

// File: rtl/mux_n_reg.sv
// N-way registered mux with valid/ready handshake; explicit-select or round-robin arbitration.
module mux_n_reg
  import cpu_pkg::*;
#(
  parameter  int WIDTH = WORD_W,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [N*WIDTH-1:0]   In,
  input  logic [N-1:0]         InValid,
  output logic [N-1:0]         InReady,
  input  logic                 Mode,
  input  logic [SEL_W-1:0]     Sel,
  output logic [WIDTH-1:0]     Out,
  output logic [SEL_W-1:0]     OutChan,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 SelErr
);
  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             vld_q, vld_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             selerr_q, selerr_d;

  logic             rr_any;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] cand;
  logic             free, grant, sel_ok, xfer;

  rr_pick #(.N(N)) u_pick (
    .req (InValid),
    .ptr (ptr_q),
    .any (rr_any),
    .idx (rr_idx)
  );

  always_comb begin
    free   = !vld_q || OutReady;
    sel_ok = int'(Sel) < N;
    if (Mode == MODE_RR) begin
      cand  = rr_idx;
      grant = rr_any;
    end else begin
      cand  = Sel;
      grant = sel_ok && InValid[Sel];
    end
    xfer = free && grant && !Reset;

    InReady = '0;
    if (xfer) InReady[cand] = 1'b1;

    out_d    = out_q;
    chan_d   = chan_q;
    vld_d    = vld_q;
    ptr_d    = ptr_q;
    selerr_d = (Mode == MODE_SEL) && !sel_ok;
    if (xfer) begin
      out_d  = In[int'(cand)*WIDTH +: WIDTH];
      chan_d = cand;
      vld_d  = 1'b1;
      // Explicit wrap keeps the pointer legal when N is not a power of two.
      if (Mode == MODE_RR) ptr_d = (int'(cand) == N - 1) ? '0 : cand + 1'b1;
    end else if (OutReady) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      out_q    <= '0;
      chan_q   <= '0;
      vld_q    <= 1'b0;
      ptr_q    <= '0;
      selerr_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      chan_q   <= chan_d;
      vld_q    <= vld_d;
      ptr_q    <= ptr_d;
      selerr_q <= selerr_d;
    end
  end

  assign Out      = out_q;
  assign OutChan  = chan_q;
  assign OutValid = vld_q;
  assign SelErr   = selerr_q;
endmodule

// File: tb/tb_mux_n_reg.sv
// Table-driven bench for mux_n_reg at N=4 (inst 0) and N=3 (inst 1) with a data scoreboard.
module tb_mux_n_reg;
  localparam int W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_a, mode_a, ordy_a, ovld_a, serr_a;
  logic [4*W-1:0]   in_a;
  logic [3:0]       iv_a, ir_a;
  logic [1:0]       sel_a, ch_a;
  logic [W-1:0]     out_a;

  logic             rst_b, mode_b, ordy_b, ovld_b, serr_b;
  logic [3*W-1:0]   in_b;
  logic [2:0]       iv_b, ir_b;
  logic [1:0]       sel_b, ch_b;
  logic [W-1:0]     out_b;

  mux_n_reg #(.WIDTH(W), .N(4)) dut_a (
    .Clock(clk), .Reset(rst_a), .In(in_a), .InValid(iv_a), .InReady(ir_a),
    .Mode(mode_a), .Sel(sel_a), .Out(out_a), .OutChan(ch_a), .OutValid(ovld_a),
    .OutReady(ordy_a), .SelErr(serr_a)
  );

  mux_n_reg #(.WIDTH(W), .N(3)) dut_b (
    .Clock(clk), .Reset(rst_b), .In(in_b), .InValid(iv_b), .InReady(ir_b),
    .Mode(mode_b), .Sel(sel_b), .Out(out_b), .OutChan(ch_b), .OutValid(ovld_b),
    .OutReady(ordy_b), .SelErr(serr_b)
  );

  typedef struct {
    bit       inst;
    bit       rst;
    bit       mode;
    bit [1:0] sel;
    bit [3:0] inv;
    bit       ordy;
    bit [3:0] exp_irdy;
    bit       exp_ovld;
    bit       exp_serr;
  } row_t;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   chan;
  } word_t;

  word_t q[$];
  int tests = 0, fails = 0;
  logic [W-1:0] exp_out [2];
  logic [1:0]   exp_ch  [2];

  function automatic logic [W-1:0] pat(int k, int row);
    if (row == 2 && k == 2) return 24'hABCDEF;
    return W'(24'h100000 * (k + 1)) ^ W'(row * 24'h000137);
  endfunction

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic step(row_t r, int row);
    logic [3:0] irdy;
    word_t      w;
    int         ch;
    // idle instance holds its state: no valids, no consumer
    rst_a = 0; mode_a = 0; sel_a = 0; iv_a = 0; ordy_a = 0;
    rst_b = 0; mode_b = 0; sel_b = 0; iv_b = 0; ordy_b = 0;
    for (int k = 0; k < 4; k++) in_a[k*W +: W] = pat(k, row);
    for (int k = 0; k < 3; k++) in_b[k*W +: W] = pat(k, row);
    if (!r.inst) begin
      rst_a = r.rst; mode_a = r.mode; sel_a = r.sel; iv_a = r.inv; ordy_a = r.ordy;
    end else begin
      rst_b = r.rst; mode_b = r.mode; sel_b = r.sel; iv_b = r.inv[2:0]; ordy_b = r.ordy;
    end
    #1;
    irdy = r.inst ? {1'b0, ir_b} : ir_a;
    chk("in_ready", row, 32'(irdy), 32'(r.exp_irdy));
    ch = -1;
    for (int k = 0; k < 4; k++) if (r.exp_irdy[k]) ch = k;
    if (ch >= 0) begin
      w.data = pat(ch, row);
      w.chan = 2'(ch);
      q.push_back(w);
    end
    @(posedge clk);
    @(negedge clk);
    if (r.rst) begin
      q.delete();
      exp_out[r.inst] = '0;
      exp_ch[r.inst]  = '0;
    end else if (ch >= 0) begin
      if (q.size() == 0) begin
        chk("scoreboard_empty", row, 32'd0, 32'd1);
      end else begin
        w = q.pop_front();
        exp_out[r.inst] = w.data;
        exp_ch[r.inst]  = w.chan;
      end
    end
    chk("out_valid", row, 32'(r.inst ? ovld_b : ovld_a), 32'(r.exp_ovld));
    chk("sel_err",   row, 32'(r.inst ? serr_b : serr_a), 32'(r.exp_serr));
    chk("out_data",  row, 32'(r.inst ? out_b : out_a), 32'(exp_out[r.inst]));
    chk("out_chan",  row, 32'(r.inst ? ch_b : ch_a), 32'(exp_ch[r.inst]));
  endtask

  row_t tbl [$];

  initial begin
    rst_a = 1; mode_a = 0; sel_a = 0; iv_a = 0; ordy_a = 0; in_a = '0;
    rst_b = 1; mode_b = 0; sel_b = 0; iv_b = 0; ordy_b = 0; in_b = '0;
    exp_out[0] = '0; exp_out[1] = '0; exp_ch[0] = '0; exp_ch[1] = '0;

    //        inst rst mode sel inv      ordy irdy     ovld serr
    tbl = '{
      '{0, 1, 0, 0, 4'b0000, 1, 4'b0000, 0, 0},
      '{1, 1, 0, 0, 4'b0000, 1, 4'b0000, 0, 0},
      // explicit select, channel 2 carries ABCDEF
      '{0, 0, 0, 2, 4'b0100, 1, 4'b0100, 1, 0},
      // round-robin from ptr 0 with all valid
      '{0, 0, 1, 0, 4'b1111, 1, 4'b0001, 1, 0},
      '{0, 0, 1, 0, 4'b1111, 1, 4'b0010, 1, 0},
      '{0, 0, 1, 0, 4'b1111, 1, 4'b0100, 1, 0},
      '{0, 0, 1, 0, 4'b1111, 1, 4'b1000, 1, 0},
      '{0, 0, 1, 0, 4'b1111, 1, 4'b0001, 1, 0},
      // backpressure for 3 cycles, inputs changing
      '{0, 0, 1, 0, 4'b1111, 0, 4'b0000, 1, 0},
      '{0, 0, 1, 0, 4'b0110, 0, 4'b0000, 1, 0},
      '{0, 0, 0, 3, 4'b1001, 0, 4'b0000, 1, 0},
      // release: ptr=1 picks channel 1 on the same edge
      '{0, 0, 1, 0, 4'b0110, 1, 4'b0010, 1, 0},
      '{0, 0, 0, 1, 4'b0000, 1, 4'b0000, 0, 0},
      '{0, 0, 0, 3, 4'b1000, 0, 4'b1000, 1, 0},
      '{0, 0, 1, 0, 4'b0000, 1, 4'b0000, 0, 0},
      // ptr=2 untouched by mode 0; scan 2,3,0 finds 0
      '{0, 0, 1, 0, 4'b0011, 1, 4'b0001, 1, 0},
      // N=3: wrap from channel 2 back to 0
      '{1, 0, 1, 0, 4'b0001, 1, 4'b0001, 1, 0},
      '{1, 0, 1, 0, 4'b0101, 1, 4'b0100, 1, 0},
      '{1, 0, 1, 0, 4'b0101, 1, 4'b0001, 1, 0},
      '{1, 0, 1, 0, 4'b0101, 1, 4'b0100, 1, 0},
      '{1, 0, 1, 0, 4'b0010, 1, 4'b0010, 1, 0},
      // Sel out of range pulses SelErr; round-robin never does
      '{1, 0, 0, 3, 4'b0111, 1, 4'b0000, 0, 1},
      '{1, 0, 0, 0, 4'b0000, 1, 4'b0000, 0, 0},
      '{1, 0, 1, 3, 4'b0000, 1, 4'b0000, 0, 0},
      // load, hold, then reset mid-hold with consumer ready
      '{1, 0, 0, 1, 4'b0010, 1, 4'b0010, 1, 0},
      '{1, 0, 0, 1, 4'b0010, 0, 4'b0000, 1, 0},
      '{1, 1, 1, 0, 4'b0111, 1, 4'b0000, 0, 0},
      // ptr was 2 before reset; grant 0 proves it cleared
      '{1, 0, 1, 0, 4'b0111, 1, 4'b0001, 1, 0}
    };

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
